hex_write_arbiter: RTL and testbench
====================================

// Module: hex_write_arbiter
// PURPOSE
//   Owns the six DE-series HEX display registers and shares them between NREQ requesters.
//   Each requester asks to write one 7-bit segment pattern to one display (address 0..5).
//   Access is granted round-robin. A clear command blanks all displays in a one-display-per-cycle sweep.
//   Sits between the board HEX0..HEX5 pins and any producer blocks (switch loaders, counters, scrollers).
// PARAMETERS
//   NREQ       2         number of requesters (1..8)
//   NDIG       6         number of HEX displays implemented (1..6); the remaining HEX outputs hold CLEAR_PAT
//   CLEAR_PAT  7'h7F     blank pattern (segments are active-low, so all segments off)
// PORTS
//   CLOCK_50   in   1         system clock; all state changes on posedge
//   RESET      in   1         asynchronous, active-high reset
//   REQ        in   NREQ      REQ[i]=1: requester i wants a write; held until GNT[i]
//   REQ_ADDR   in   3*NREQ    display address of requester i, bits [3i+2:3i]
//   REQ_DATA   in   7*NREQ    segment pattern of requester i, bits [7i+6:7i]
//   CLR        in   1         1-cycle pulse: blank all displays
//   GNT        out  NREQ      one-hot, 1-cycle grant pulse (registered)
//   ERR        out  NREQ      1-cycle pulse together with GNT[i] when REQ_ADDR >= NDIG
//   BUSY       out  1         1 while state is WRITE or CLEAR
//   HEX0..HEX5 out  7 each    display registers
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, ptr=0, clr_pend=0, GNT=0, ERR=0, BUSY=0, HEX0..5=CLEAR_PAT.
//     Reset in the middle of a WRITE or CLEAR aborts it. No partial write survives.
//   clr_pend: set on any edge where CLR=1. Cleared on entry to CLEAR, unless CLR=1 again at that same edge.
//   FSM states: IDLE, WRITE, CLEAR.
//   IDLE:
//     - If clr_pend or CLR: go to CLEAR with k=0.
//       CLR has priority over REQ in the same cycle.
//     - Else if any REQ: choose the winner w, the first set REQ bit searching ptr, ptr+1, ... mod NREQ.
//       Latch w, REQ_ADDR[w] and REQ_DATA[w]; go to WRITE.
//     - Else stay in IDLE.
//   WRITE (exactly 1 cycle):
//     - GNT[w]=1 and BUSY=1 for the whole cycle.
//     - ERR[w]=1 if the latched address >= NDIG.
//     - At the closing edge: if the address < NDIG, HEX[addr] <= latched data; otherwise no HEX change.
//       Also ptr <= (w+1) mod NREQ, then go to IDLE.
//   CLEAR (NDIG cycles, k = 0..NDIG-1):
//     - BUSY=1, GNT=0.
//     - At each edge HEX[k] <= CLEAR_PAT and k increments.
//     - After k=NDIG-1, go to IDLE. If CLR arrived during the sweep, clr_pend is set again and a second sweep follows.
//   Handshake:
//     - A requester keeps REQ, ADDR and DATA stable until it sees GNT=1.
//     - It deasserts REQ at the edge that ends the GNT cycle, so it is never granted twice.
//     - ADDR and DATA are captured at IDLE->WRITE. Later changes do not affect the write in progress.
//   Latency:
//     - REQ rising in IDLE -> GNT in the next cycle -> HEX value visible 2 edges after REQ was sampled.
//     - Peak throughput is 1 write per 2 cycles.
//   Fairness: with all REQ held, grants rotate 0,1,..,NREQ-1,0,...; no requester waits more than NREQ grants.
//   REQ held during CLEAR simply waits. It is arbitrated in the first IDLE cycle after the sweep.
//   Unimplemented displays (index >= NDIG) stay at CLEAR_PAT permanently.
//   GNT, ERR and BUSY are driven from registered state only. No combinational path from any input to any output.
// TESTING
//   1. Reset: RESET high mid-CLEAR sweep -> all HEX=7'h7F, GNT=0, BUSY=0 at once. State is IDLE after release.
//   2. Single write: REQ[0]=1, ADDR=3, DATA=7'h40 -> GNT[0] pulses 1 cycle later; HEX3=7'h40 on the following edge.
//      All other HEX stay at 7'h7F.
//   3. Round-robin: REQ=2'b11 held, ADDRs 0/1, deasserted only per handshake -> grant order 0 then 1.
//      With re-requests, the order continues 0,1,0,1.
//   4. Bad address: REQ[1]=1, ADDR=6 -> GNT[1] and ERR[1] pulse together; no HEX changes; ptr advances to 0.
//   5. Clear priority: CLR and REQ[0] in the same IDLE cycle -> 6 cycles of CLEAR, BUSY=1, HEX0..5 blanked in order.
//      GNT[0] follows in the cycle after the sweep ends.
//   6. CLR during sweep: second CLR pulse at k=2 -> BUSY stays high for 12 cycles total; no GNT during that time.

Source files
------------

// File: rtl/hex_write_arbiter_if.sv
// Request/grant bundle between producer blocks and the HEX write arbiter.
// Requester i uses lane i of REQ, REQ_ADDR (3 bits/lane) and REQ_DATA (7 bits/lane).
interface hex_write_arbiter_if #(
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0]   REQ;
  logic [3*NREQ-1:0] REQ_ADDR;
  logic [7*NREQ-1:0] REQ_DATA;
  logic              CLR;
  logic [NREQ-1:0]   GNT;
  logic [NREQ-1:0]   ERR;
  logic              BUSY;

  // Producer side: drives requests and the clear pulse, watches grants.
  modport master (
    output REQ, REQ_ADDR, REQ_DATA, CLR,
    input  GNT, ERR, BUSY
  );

  // Arbiter side.
  modport slave (
    input  REQ, REQ_ADDR, REQ_DATA, CLR,
    output GNT, ERR, BUSY
  );

endinterface

// File: rtl/hex_write_arbiter.sv
// Owns the six HEX display registers and shares write access between NREQ
// requesters with round-robin arbitration. A clear command blanks the
// implemented displays one per cycle. GNT/ERR/BUSY come straight from flops.
module hex_write_arbiter #(
  parameter int         NREQ      = 2,
  parameter int         NDIG      = 6,
  parameter logic [6:0] CLEAR_PAT = 7'h7F
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  hex_write_arbiter_if.slave  bus,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5
);

  localparam int         PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] NDIG_L = 3'(NDIG);
  localparam logic [2:0] K_LAST = 3'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_CLEAR
  } state_e;

  // Request captured at IDLE->WRITE; later changes on the bus are ignored.
  typedef struct packed {
    logic [PW-1:0] w;
    logic [2:0]    addr;
    logic [6:0]    data;
  } wreq_t;

  state_e          state_q,    state_d;
  logic [PW-1:0]   ptr_q,      ptr_d;
  wreq_t           wreq_q,     wreq_d;
  logic [2:0]      k_q,        k_d;
  logic            clr_pend_q, clr_pend_d;
  logic [NREQ-1:0] gnt_q,      gnt_d;
  logic [NREQ-1:0] err_q,      err_d;
  logic            busy_q,     busy_d;
  logic [6:0]      hex_q [6];
  logic [6:0]      hex_d [6];

  logic [PW-1:0]   win;
  logic [2:0]      win_addr;
  logic [6:0]      win_data;
  int              idx;

  // Round-robin search: first set REQ bit starting at ptr and wrapping.
  always_comb begin
    win = '0;
    idx = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      // Walking downward lets the closest-to-ptr hit overwrite farther ones.
      if (bus.REQ[idx]) win = PW'(idx);
    end
    win_addr = bus.REQ_ADDR[3*win +: 3];
    win_data = bus.REQ_DATA[7*win +: 7];
  end

  // Next-state, datapath and registered-output logic for the arbiter FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    wreq_d     = wreq_q;
    k_d        = k_q;
    clr_pend_d = clr_pend_q | bus.CLR;
    gnt_d      = '0;
    err_d      = '0;
    busy_d     = 1'b0;
    hex_d      = hex_q;

    case (state_q)
      S_IDLE: begin
        if (clr_pend_q || bus.CLR) begin
          // A pending clear is consumed here; a fresh CLR on this edge only
          // stays pending if it is not the one that triggered this sweep.
          state_d    = S_CLEAR;
          k_d        = '0;
          clr_pend_d = clr_pend_q & bus.CLR;
          busy_d     = 1'b1;
        end else if (|bus.REQ) begin
          state_d     = S_WRITE;
          wreq_d.w    = win;
          wreq_d.addr = win_addr;
          wreq_d.data = win_data;
          gnt_d[win]  = 1'b1;
          err_d[win]  = (win_addr >= NDIG_L);
          busy_d      = 1'b1;
        end
      end

      S_WRITE: begin
        for (int i = 0; i < 6; i++) begin
          if ((wreq_q.addr < NDIG_L) && (wreq_q.addr == 3'(i))) hex_d[i] = wreq_q.data;
        end
        if (wreq_q.w == PW'(NREQ - 1)) ptr_d = '0;
        else                           ptr_d = wreq_q.w + 1'b1;
        state_d = S_IDLE;
      end

      S_CLEAR: begin
        for (int i = 0; i < 6; i++) begin
          if (k_q == 3'(i)) hex_d[i] = CLEAR_PAT;
        end
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
        end else begin
          k_d    = k_q + 1'b1;
          busy_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and display registers; reset aborts any write or sweep in flight.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (RESET) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      wreq_q     <= '0;
      k_q        <= '0;
      clr_pend_q <= 1'b0;
      gnt_q      <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      // NOTE: the display registers are visible board outputs, so this small
      // register file is reset explicitly rather than left uninitialised.
      hex_q      <= '{default: CLEAR_PAT};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wreq_q     <= wreq_d;
      k_q        <= k_d;
      clr_pend_q <= clr_pend_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      hex_q      <= hex_d;
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.ERR  = err_q;
  assign bus.BUSY = busy_q;

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_write_arbiter.sv
// Directed bench for hex_write_arbiter: expected grants are queued when a
// request is driven and popped when GNT appears; a display model follows
// writes and clear sweeps and is compared around every clock edge.
module tb_hex_write_arbiter;

  localparam int NREQ = 2;

  typedef struct {
    int         idx;
    logic       err;
    logic [2:0] addr;
    logic [6:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [6:0] hex_o [6];

  hex_write_arbiter_if #(.NREQ(NREQ)) bus ();

  hex_write_arbiter #(
    .NREQ      (NREQ),
    .NDIG      (6),
    .CLEAR_PAT (7'h7F)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus),
    .HEX0     (hex_o[0]),
    .HEX1     (hex_o[1]),
    .HEX2     (hex_o[2]),
    .HEX3     (hex_o[3]),
    .HEX4     (hex_o[4]),
    .HEX5     (hex_o[5])
  );

  int              checks   = 0;
  int              failures = 0;
  int              busy_cnt = 0;
  int              clr_k    = 0;
  logic [NREQ-1:0] seen_gnt;
  logic [6:0]      model [6];
  exp_t            sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] hex_flat();
    return {hex_o[5], hex_o[4], hex_o[3], hex_o[2], hex_o[1], hex_o[0]};
  endfunction

  function automatic logic [41:0] model_flat();
    return {model[5], model[4], model[3], model[2], model[1], model[0]};
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) model[i] = 7'h7F;
    clr_k = 0;
  endtask

  // Raise request i and queue its expected grant.
  task automatic req(input int i, input logic [2:0] addr, input logic [6:0] data);
    exp_t e;
    bus.REQ_ADDR[3*i +: 3] = addr;
    bus.REQ_DATA[7*i +: 7] = data;
    bus.REQ[i]             = 1'b1;
    e.idx  = i;
    e.addr = addr;
    e.data = data;
    e.err  = (addr >= 3'd6);
    sb.push_back(e);
  endtask

  // One clock cycle: sample at negedge, score grants, follow sweeps, then
  // after the edge drop granted REQs and the CLR pulse.
  task automatic tick();
    exp_t            e;
    logic [NREQ-1:0] g;
    @(negedge clk);
    check("hex_pre", hex_flat(), model_flat());
    g        = bus.GNT;
    seen_gnt = g;
    if (bus.BUSY) busy_cnt++;
    if (g != '0) begin
      check("busy_in_write", bus.BUSY, 1'b1);
      if (sb.size() == 0) begin
        check("unexpected_gnt", g, '0);
      end else begin
        e = sb.pop_front();
        check("gnt", g, onehot(e.idx));
        check("err", bus.ERR, e.err ? onehot(e.idx) : '0);
        if (e.addr < 3'd6) model[e.addr] = e.data;
      end
    end else begin
      check("err_no_gnt", bus.ERR, '0);
      if (bus.BUSY) begin
        model[clr_k] = 7'h7F;
        clr_k        = (clr_k == 5) ? 0 : clr_k + 1;
      end
    end
    @(posedge clk);
    #1;
    bus.REQ = bus.REQ & ~g;
    bus.CLR = 1'b0;
    check("hex_post", hex_flat(), model_flat());
  endtask

  task automatic run_until_empty(input string tag, input int max);
    for (int n = 0; n < max; n++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    int rem [NREQ];

    rst          = 1'b1;
    bus.REQ      = '0;
    bus.REQ_ADDR = '0;
    bus.REQ_DATA = '0;
    bus.CLR      = 1'b0;
    seen_gnt     = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_hex", hex_flat(), model_flat());
    check("rst_gnt", bus.GNT, '0);
    check("rst_err", bus.ERR, '0);
    check("rst_busy", bus.BUSY, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // Single write with exact latency; bus changes after capture are ignored
    req(0, 3'd3, 7'h40);
    tick();
    check("lat_no_early_gnt", seen_gnt, '0);
    bus.REQ_ADDR[2:0] = 3'd1;
    bus.REQ_DATA[6:0] = 7'h2A;
    tick();
    check("lat_gnt", seen_gnt, 2'b01);
    check("single_hex3", hex_o[3], 7'h40);
    check("single_hex1", hex_o[1], 7'h7F);
    check("single_drained", sb.size(), 0);

    // Bad address: GNT and ERR together, no display change, ptr back to 0
    req(1, 3'd6, 7'h3C);
    run_until_empty("badaddr", 10);

    // Round-robin with re-requests: 0,1,0,1
    rem[0] = 1;
    rem[1] = 1;
    req(0, 3'd0, 7'h01);
    req(1, 3'd1, 7'h02);
    for (int n = 0; n < 30; n++) begin
      if (sb.size() == 0) break;
      tick();
      if (!bus.REQ[0] && rem[0] > 0) begin rem[0]--; req(0, 3'd0, 7'h11); end
      if (!bus.REQ[1] && rem[1] > 0) begin rem[1]--; req(1, 3'd1, 7'h12); end
    end
    check("rr_drained", sb.size(), 0);
    check("rr_hex0", hex_o[0], 7'h11);
    check("rr_hex1", hex_o[1], 7'h12);

    // CLR and REQ in the same IDLE cycle: full sweep first, then the grant
    busy_cnt = 0;
    bus.CLR  = 1'b1;
    req(0, 3'd5, 7'h55);
    for (int n = 0; n < 20; n++) begin
      tick();
      if (seen_gnt != '0) begin
        check("clrprio_cycles", n + 1, 9);
        break;
      end
    end
    check("clrprio_drained", sb.size(), 0);
    check("clrprio_busy", busy_cnt, 7);
    check("clrprio_hex5", hex_o[5], 7'h55);

    // Second CLR during the sweep (at k=2): two sweeps, 12 busy cycles, no grant
    busy_cnt = 0;
    bus.CLR  = 1'b1;
    repeat (3) tick();
    bus.CLR = 1'b1;
    repeat (17) tick();
    check("clr2_busy", busy_cnt, 12);
    check("clr2_idle", bus.BUSY, 1'b0);
    check("clr2_hex5", hex_o[5], 7'h7F);

    // Reset in the middle of a sweep: immediate blanking and IDLE
    req(0, 3'd2, 7'h0F);
    run_until_empty("prereset", 10);
    check("prereset_hex2", hex_o[2], 7'h0F);
    bus.CLR = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_hex", hex_flat(), model_flat());
    check("midrst_gnt", bus.GNT, '0);
    check("midrst_busy", bus.BUSY, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_cnt = 0;
    repeat (3) tick();
    check("postrst_idle", busy_cnt, 0);

    // ptr was 1 before reset; after reset the order must start at 0
    req(0, 3'd4, 7'h24);
    req(1, 3'd5, 7'h25);
    run_until_empty("postrst_rr", 20);
    check("postrst_hex4", hex_o[4], 7'h24);
    check("postrst_hex5", hex_o[5], 7'h25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
